// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC redirect arbiter with stall hold slot, flush timer and rollback checkpoint
// Requests are arbitrated rollback > JR > branch; every issued redirect is a registered one-cycle PC load.
module pc_redirect_ctrl #(
  parameter int                ADDR_W       = 32,
  parameter int                FLUSH_CYCLES = 1,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              PCWrite,
  input  logic              branch_signal,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              JR_branch_signal,
  input  logic [ADDR_W-1:0] JR_branch_addr,
  input  logic              dont_branch,
  input  logic [ADDR_W-1:0] fallthrough_pc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_IF_ID,
  output logic              pending,
  output logic              drop_pulse,
  output logic [15:0]       redirect_count
);

  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_FLUSH} state_t;

  localparam logic [1:0] PRIO_BR    = 2'd0;
  localparam logic [1:0] PRIO_JR    = 2'd1;
  localparam logic [1:0] PRIO_RB    = 2'd2;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_pc_load;
  logic [ADDR_W-1:0] r_pc_target;
  logic              r_drop;
  logic [15:0]       r_count;
  logic [3:0]        r_flush_cnt;
  logic [ADDR_W-1:0] r_ckpt;
  logic              r_ckpt_valid;
  logic [1:0]        r_pend_prio;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [ADDR_W-1:0] r_pend_fall;

  logic              w_rb_ok;
  logic              w_new_req;
  logic [1:0]        w_new_prio;
  logic [ADDR_W-1:0] w_new_addr;
  logic              w_new_drop;
  logic              w_hold;
  logic              w_take_new;
  logic              w_cand_valid;
  logic [1:0]        w_cand_prio;
  logic [ADDR_W-1:0] w_cand_addr;
  logic [ADDR_W-1:0] w_cand_fall;
  logic              w_issue;
  logic              w_latch;
  logic              w_drop;
  logic [3:0]        w_flush_next;

  // A rollback without a live checkpoint is not a request; it only counts as a drop.
  always_comb begin
    w_rb_ok    = dont_branch & r_ckpt_valid;
    w_new_req  = w_rb_ok | JR_branch_signal | branch_signal;
    w_new_prio = PRIO_BR;
    w_new_addr = branch_addr;
    if (w_rb_ok) begin
      w_new_prio = PRIO_RB;
      w_new_addr = r_ckpt;
    end else if (JR_branch_signal) begin
      w_new_prio = PRIO_JR;
      w_new_addr = JR_branch_addr;
    end
    w_new_drop = (dont_branch & ~r_ckpt_valid)
               | (w_rb_ok & (JR_branch_signal | branch_signal))
               | (JR_branch_signal & branch_signal);
  end

  // In HOLD a new request of equal or higher priority displaces the slot; either way one is discarded.
  always_comb begin
    w_hold       = (r_state == ST_HOLD);
    w_cand_valid = w_new_req | w_hold;
    w_take_new   = w_new_req & (~w_hold | (w_new_prio >= r_pend_prio));
    w_cand_prio  = w_take_new ? w_new_prio     : r_pend_prio;
    w_cand_addr  = w_take_new ? w_new_addr     : r_pend_addr;
    w_cand_fall  = w_take_new ? fallthrough_pc : r_pend_fall;
    w_issue      = w_cand_valid & PCWrite;
    w_latch      = w_cand_valid & ~PCWrite;
    w_drop       = w_new_drop | (w_hold & w_new_req);
  end

  always_comb begin
    w_flush_next = 4'd0;
    w_next_state = ST_RUN;
    if (w_issue) begin
      w_flush_next = FLUSH_INIT;
    end else if (r_flush_cnt != 4'd0) begin
      w_flush_next = r_flush_cnt - 4'd1;
    end
    if (w_issue) begin
      w_next_state = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else if (w_latch) begin
      w_next_state = ST_HOLD;
    end else if ((r_state == ST_FLUSH) && (w_flush_next != 4'd0)) begin
      w_next_state = ST_FLUSH;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state      <= ST_RUN;
      r_pc_load    <= 1'b0;
      r_pc_target  <= RESET_PC;
      r_drop       <= 1'b0;
      r_count      <= 16'd0;
      r_flush_cnt  <= 4'd0;
      r_ckpt       <= RESET_PC;
      r_ckpt_valid <= 1'b0;
      r_pend_prio  <= PRIO_BR;
      r_pend_addr  <= '0;
      r_pend_fall  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_pc_load   <= w_issue;
      r_drop      <= w_drop;
      r_flush_cnt <= w_flush_next;
      if (w_latch) begin
        r_pend_prio <= w_cand_prio;
        r_pend_addr <= w_cand_addr;
        r_pend_fall <= w_cand_fall;
      end
      if (w_issue) begin
        r_pc_target <= w_cand_addr;
        r_count     <= r_count + 16'd1;
        if (w_cand_prio == PRIO_BR) begin
          r_ckpt       <= w_cand_fall;
          r_ckpt_valid <= 1'b1;
        end else if (w_cand_prio == PRIO_RB) begin
          r_ckpt_valid <= 1'b0;
        end
      end
    end
  end

  assign pc_load        = r_pc_load;
  assign pc_target      = r_pc_target;
  assign flush_IF_ID    = (r_flush_cnt != 4'd0);
  assign pending        = (r_state == ST_HOLD);
  assign drop_pulse     = r_drop;
  assign redirect_count = r_count;

endmodule
